// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES-128 core sequencer: block/key sizes and FSM encoding.
package aes_ctrl_pkg;
  localparam int AES_NR    = 10;
  localparam int AES_NKEYS = AES_NR + 1;
  localparam int AES_BLK_W = 128;
  localparam int AES_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } ctrl_state_e;
endpackage

// File: rtl/aes_rkey_mem.sv
// Round-key register file with a per-entry loaded mask and asynchronous read.
// kill clears only the mask; key contents persist but a full reload is still required.
module aes_rkey_mem
  import aes_ctrl_pkg::*;
#(
  parameter int NKEYS = AES_NKEYS
) (
  input  logic                 clk,
  input  logic                 kill,
  input  logic                 we_i,
  input  logic [AES_IDX_W-1:0] waddr_i,
  input  logic [AES_BLK_W-1:0] wdata_i,
  input  logic [AES_IDX_W-1:0] raddr_i,
  output logic [AES_BLK_W-1:0] rdata_o,
  output logic                 full_o
);
  localparam logic [AES_IDX_W-1:0] LAST = AES_IDX_W'(NKEYS - 1);

  logic [AES_BLK_W-1:0] key_q [NKEYS];
  logic [NKEYS-1:0]     mask_q;
  logic                 wr_ok;

  assign wr_ok = we_i && (waddr_i <= LAST);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      key_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      mask_q <= '0;
    end else if (wr_ok) begin
      mask_q <= mask_q | ({{(NKEYS-1){1'b0}}, 1'b1} << waddr_i);
    end
  end

  assign rdata_o = (raddr_i <= LAST) ? key_q[raddr_i] : '0;
  assign full_o  = &mask_q;
endmodule

// File: rtl/aes_128_core_ctrl.sv
// AES-128 core sequencer: key file, one-block launch, round-key feed, 1-deep result buffer.
// Optional launch-to-result watchdog is built when AES_CTRL_WDOG_EN is defined.
module aes_128_core_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR = AES_NR
`ifdef AES_CTRL_WDOG_EN
  , parameter int TMO_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 kill,
  input  logic                 cfg_we,
  input  logic [AES_IDX_W-1:0] cfg_addr,
  input  logic [AES_BLK_W-1:0] cfg_key,
  input  logic                 s_valid,
  input  logic [AES_BLK_W-1:0] s_data,
  output logic                 s_ready,
  output logic                 core_in_en,
  output logic [AES_BLK_W-1:0] core_in_data,
  output logic [AES_BLK_W-1:0] core_key_round,
  input  logic                 core_key_ready,
  input  logic                 core_out_en,
  input  logic [AES_BLK_W-1:0] core_out_data,
  output logic                 m_valid,
  output logic [AES_BLK_W-1:0] m_data,
  input  logic                 m_ready,
  output logic                 cfg_err,
  output logic                 seq_err,
  output logic                 tmo_err
);
  localparam logic [AES_IDX_W-1:0] LAST_IDX = AES_IDX_W'(NR);

  ctrl_state_e          state_q, state_d;
  logic [AES_IDX_W-1:0] key_idx_q, key_idx_d;
  logic                 core_in_en_q, core_in_en_d;
  logic [AES_BLK_W-1:0] core_in_data_q, core_in_data_d;
  logic                 m_valid_q, m_valid_d;
  logic [AES_BLK_W-1:0] m_data_q, m_data_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 seq_err_q, seq_err_d;
  logic                 keys_full, hs, cfg_ok, wdog_hit;

  assign s_ready = (state_q == ST_IDLE) && keys_full && !m_valid_q;
  assign hs      = s_valid && s_ready;
  // A write colliding with an accepted block loses: the block owns the cycle.
  assign cfg_ok    = cfg_we && (state_q == ST_IDLE) && (cfg_addr <= LAST_IDX) && !hs;
  assign cfg_err_d = cfg_we && !cfg_ok;

  aes_rkey_mem #(.NKEYS(NR + 1)) u_rkey_mem (
    .clk     (clk),
    .kill    (kill),
    .we_i    (cfg_ok),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_key),
    .raddr_i (key_idx_q),
    .rdata_o (core_key_round),
    .full_o  (keys_full)
  );

`ifdef AES_CTRL_WDOG_EN
  localparam int                WDOG_W   = $clog2(TMO_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TMO_CYCLES);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              tmo_err_q;

  always_comb begin
    wdog_d   = '0;
    wdog_hit = 1'b0;
    if (state_q == ST_RUN) begin
      wdog_d   = wdog_q + WDOG_W'(1);
      wdog_hit = (wdog_d == WDOG_LIM) && !core_out_en;
    end else begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      wdog_q    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      tmo_err_q <= wdog_hit;
    end
  end

  assign tmo_err = tmo_err_q;
`else
  assign wdog_hit = 1'b0;
  assign tmo_err  = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    key_idx_d      = key_idx_q;
    core_in_en_d   = 1'b0;
    core_in_data_d = '0;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    seq_err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        seq_err_d = core_key_ready || core_out_en;
        if (hs) begin
          state_d        = ST_LAUNCH;
          key_idx_d      = '0;
          core_in_en_d   = 1'b1;
          core_in_data_d = s_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        seq_err_d = core_key_ready || core_out_en;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        // out_en has priority over both the watchdog and a same-cycle key_ready.
        if (core_out_en) begin
          m_data_d  = core_out_data;
          m_valid_d = 1'b1;
          state_d   = ST_HOLD;
          seq_err_d = (key_idx_q != LAST_IDX);
        end else if (wdog_hit) begin
          state_d   = ST_IDLE;
          key_idx_d = '0;
        end else if (core_key_ready) begin
          if (key_idx_q == LAST_IDX) begin
            seq_err_d = 1'b1;
          end else begin
            key_idx_d = key_idx_q + 4'd1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        seq_err_d = core_key_ready || core_out_en;
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
          key_idx_d = '0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        key_idx_d = '0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q        <= ST_IDLE;
      key_idx_q      <= '0;
      core_in_en_q   <= 1'b0;
      core_in_data_q <= '0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      cfg_err_q      <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_idx_q      <= key_idx_d;
      core_in_en_q   <= core_in_en_d;
      core_in_data_q <= core_in_data_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      cfg_err_q      <= cfg_err_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign core_in_en   = core_in_en_q;
  assign core_in_data = core_in_data_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign cfg_err      = cfg_err_q;
  assign seq_err      = seq_err_q;
endmodule

// File: tb/tb_aes_128_core_ctrl.sv
// Bench for aes_128_core_ctrl: a behavioural AES-128 core fed by the DUT's round keys,
// checked against a reference cipher built from FIPS-197 key expansion.
module tb_aes_128_core_ctrl;
  logic         clk = 1'b0;
  logic         kill;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [127:0] cfg_key;
  logic         s_valid;
  logic [127:0] s_data;
  logic         s_ready;
  logic         core_in_en;
  logic [127:0] core_in_data;
  logic [127:0] core_key_round;
  logic         core_key_ready;
  logic         core_out_en;
  logic [127:0] core_out_data;
  logic         m_valid;
  logic [127:0] m_data;
  logic         m_ready;
  logic         cfg_err;
  logic         seq_err;
  logic         tmo_err;

  int total = 0;
  int bad = 0;
  int seq_cnt = 0;
  int tmo_cnt = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk [11];
  logic [127:0] core_st;

  always #5 clk = ~clk;

  aes_128_core_ctrl dut (
    .clk(clk), .kill(kill), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_key(cfg_key),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .core_in_en(core_in_en), .core_in_data(core_in_data), .core_key_round(core_key_round),
    .core_key_ready(core_key_ready), .core_out_en(core_out_en), .core_out_data(core_out_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .cfg_err(cfg_err), .seq_err(seq_err), .tmo_err(tmo_err)
  );

  always @(posedge clk) begin
    if (seq_err === 1'b1) seq_cnt++;
    if (tmo_err === 1'b1) tmo_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse plus affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Byte i of a block lives at bits [8i+7:8i]; byte 4c+r is column c, row r.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    logic [127:0] m;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[8*(4*c+r) +: 8] = sbox[s[8*(4*((c+r)%4)+r) +: 8]];
    m = t;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[8*(4*c) +: 8]; a1 = t[8*(4*c+1) +: 8];
        a2 = t[8*(4*c+2) +: 8]; a3 = t[8*(4*c+3) +: 8];
        m[8*(4*c)   +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        m[8*(4*c+1) +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        m[8*(4*c+2) +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        m[8*(4*c+3) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    return m ^ k;
  endfunction

  task automatic expand_key(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[7:0] = t[7:0] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r == 10);
    return s;
  endfunction

  task automatic load_keys(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_key = rk[i];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic new_keys();
    expand_key(rnd128());
    load_keys(0, 10);
  endtask

  task automatic send_block(input logic [127:0] pt);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL s_ready_wait: got %b want 1", s_ready); end
    s_valid = 1'b1; s_data = pt;
    tick();
    s_valid = 1'b0; s_data = rnd128();
    total++; if (core_in_en !== 1'b1 || core_in_data !== pt) begin bad++;
      $display("FAIL launch: en=%b data=%h want en=1 data=%h", core_in_en, core_in_data, pt); end
    tick();
    total++; if (core_in_en !== 1'b0 || core_in_data !== 128'h0) begin bad++;
      $display("FAIL launch_end: en=%b data=%h want en=0 data=0", core_in_en, core_in_data); end
    core_st = pt;
  endtask

  // Core model: consume the presented round key, then request the next one.
  task automatic core_step_key(input int r);
    total++; if (core_key_round !== rk[r]) begin bad++;
      $display("FAIL key_round[%0d]: got %h want %h", r, core_key_round, rk[r]); end
    core_st = (r == 0) ? (core_st ^ core_key_round) : aes_round(core_st, core_key_round, 1'b0);
    core_key_ready = 1'b1;
    tick();
    core_key_ready = 1'b0;
  endtask

  task automatic finish_block(input logic [127:0] exp);
    total++; if (core_key_round !== rk[10]) begin bad++;
      $display("FAIL key_round[10]: got %h want %h", core_key_round, rk[10]); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL m_valid_early: got %b want 0", m_valid); end
    core_st = aes_round(core_st, core_key_round, 1'b1);
    core_out_en = 1'b1; core_out_data = core_st;
    tick();
    core_out_en = 1'b0; core_out_data = rnd128();
    total++; if (m_valid !== 1'b1 || m_data !== exp) begin bad++;
      $display("FAIL result: m_valid=%b m_data=%h want 1 %h", m_valid, m_data, exp); end
    total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL seq_err_final: got %b want 0", seq_err); end
  endtask

  task automatic release_out();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++;
      $display("FAIL release: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
  endtask

  task automatic run_full(input logic [127:0] pt, output logic [127:0] got);
    logic [127:0] exp;
    int s0;
    exp = aes_ref(pt);
    s0 = seq_cnt;
    send_block(pt);
    for (int r = 0; r < 10; r++) core_step_key(r);
    finish_block(exp);
    got = m_data;
    release_out();
    total++; if (seq_cnt != s0) begin bad++; $display("FAIL seq_quiet: got %0d pulses want 0", seq_cnt - s0); end
  endtask

  task automatic test_reset();
    kill = 1'b1; tick(); tick(); kill = 1'b0;
    total++; if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 128'h0) begin bad++;
      $display("FAIL reset_out: s_ready=%b m_valid=%b m_data=%h want 0 0 0", s_ready, m_valid, m_data); end
    total++; if (core_in_en !== 1'b0 || core_in_data !== 128'h0) begin bad++;
      $display("FAIL reset_core: en=%b data=%h want 0 0", core_in_en, core_in_data); end
    total++; if ({cfg_err, seq_err, tmo_err} !== 3'b000) begin bad++;
      $display("FAIL reset_err: got %b want 000", {cfg_err, seq_err, tmo_err}); end
  endtask

  task automatic test_fips();
    logic [127:0] got;
    expand_key(128'h0f0e0d0c0b0a09080706050403020100);
    load_keys(0, 10);
    run_full(128'hffeeddccbbaa99887766554433221100, got);
    total++; if (got !== 128'h5ac5b47080b7cdd830047b6ad8e0c469) begin bad++;
      $display("FAIL fips_vector: got %h want 5ac5b47080b7cdd830047b6ad8e0c469", got); end
  endtask

  task automatic test_mask();
    logic ok;
    kill = 1'b1; tick(); kill = 1'b0;
    load_keys(0, 9);
    ok = 1'b1;
    s_valid = 1'b1; s_data = rnd128();
    for (int i = 0; i < 4; i++) begin
      if (s_ready !== 1'b0 || core_in_en !== 1'b0) ok = 1'b0;
      tick();
    end
    s_valid = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL partial_keys: s_ready/launch seen with key10 missing, want none"); end
    load_keys(10, 10);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mask_full: s_ready=%b want 1", s_ready); end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, exp, got;
    logic ok;
    new_keys();
    pt = rnd128(); exp = aes_ref(pt);
    send_block(pt);
    for (int r = 0; r < 10; r++) core_step_key(r);
    finish_block(exp);
    ok = 1'b1;
    s_valid = 1'b1; s_data = rnd128();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== exp || s_ready !== 1'b0 || core_in_en !== 1'b0) ok = 1'b0;
    end
    s_valid = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL hold_stable: m_valid=%b m_data=%h s_ready=%b want 1 %h 0", m_valid, m_data, s_ready, exp); end
    release_out();
    run_full(rnd128(), got);
  endtask

  task automatic test_cfg_err();
    logic [127:0] pt, exp, got;
    new_keys();
    pt = rnd128(); exp = aes_ref(pt);
    send_block(pt);
    for (int r = 0; r < 4; r++) core_step_key(r);
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_key = rnd128();
    core_step_key(4);
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_run: got %b want 1", cfg_err); end
    core_step_key(5);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err); end
    for (int r = 6; r < 10; r++) core_step_key(r);
    finish_block(exp);
    release_out();
    cfg_we = 1'b1; cfg_addr = 4'd12; cfg_key = rnd128();
    tick();
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_addr: got %b want 1", cfg_err); end
    // Write and handshake in the same cycle: block accepted, write dropped.
    pt = rnd128(); exp = aes_ref(pt);
    s_valid = 1'b1; s_data = pt;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_key = rnd128();
    tick();
    s_valid = 1'b0; cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1 || core_in_en !== 1'b1) begin bad++;
      $display("FAIL cfg_vs_hs: cfg_err=%b core_in_en=%b want 1 1", cfg_err, core_in_en); end
    tick();
    core_st = pt;
    for (int r = 0; r < 10; r++) core_step_key(r);
    finish_block(exp);
    release_out();
    run_full(rnd128(), got);
  endtask

  task automatic test_seq();
    logic [127:0] pt, exp, d;
    new_keys();
    pt = rnd128(); exp = aes_ref(pt);
    send_block(pt);
    for (int r = 0; r < 10; r++) core_step_key(r);
    core_key_ready = 1'b1; tick(); core_key_ready = 1'b0;
    total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL seq_extra_kr: got %b want 1", seq_err); end
    total++; if (core_key_round !== rk[10]) begin bad++;
      $display("FAIL key_saturate: got %h want %h", core_key_round, rk[10]); end
    finish_block(exp);
    release_out();
    core_out_en = 1'b1; tick(); core_out_en = 1'b0;
    total++; if (seq_err !== 1'b1 || m_valid !== 1'b0) begin bad++;
      $display("FAIL seq_idle_out: seq_err=%b m_valid=%b want 1 0", seq_err, m_valid); end
    tick();
    total++; if (seq_err !== 1'b0 || s_ready !== 1'b1) begin bad++;
      $display("FAIL seq_idle_after: seq_err=%b s_ready=%b want 0 1", seq_err, s_ready); end
    // Early out_en: still captured, flagged as a sequence error.
    send_block(rnd128());
    for (int r = 0; r < 5; r++) core_step_key(r);
    d = rnd128();
    core_out_en = 1'b1; core_out_data = d; tick(); core_out_en = 1'b0;
    total++; if (m_valid !== 1'b1 || m_data !== d || seq_err !== 1'b1) begin bad++;
      $display("FAIL seq_early_out: m_valid=%b m_data=%h seq_err=%b want 1 %h 1", m_valid, m_data, seq_err, d); end
    release_out();
  endtask

  task automatic test_kill();
    logic ok;
    new_keys();
    send_block(rnd128());
    for (int r = 0; r < 4; r++) core_step_key(r);
    kill = 1'b1; tick(); kill = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid !== 1'b0 || s_ready !== 1'b0 || core_in_en !== 1'b0) ok = 1'b0;
      tick();
    end
    total++; if (!ok) begin bad++; $display("FAIL kill_run: m_valid=%b s_ready=%b want 0 0", m_valid, s_ready); end
    load_keys(0, 10);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL kill_reload: s_ready=%b want 1", s_ready); end
  endtask

  task automatic test_wdog();
    logic [127:0] pt, exp, got;
    int cyc;
    int t0;
    pt = rnd128(); exp = aes_ref(pt);
    t0 = tmo_cnt;
    send_block(pt);
    for (int r = 0; r < 10; r++) core_step_key(r);
    cyc = 10;
`ifdef AES_CTRL_WDOG_EN
    while (tmo_err !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    total++; if (cyc != 64) begin bad++; $display("FAIL tmo_cycles: got %0d want 64", cyc); end
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++;
      $display("FAIL tmo_idle: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
    tick();
    total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_pulse: got %b want 0", tmo_err); end
    run_full(rnd128(), got);
`else
    while (cyc < 90) begin tick(); cyc++; end
    total++; if (tmo_cnt != t0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin bad++;
      $display("FAIL no_wdog_wait: tmo pulses=%0d s_ready=%b m_valid=%b want 0 0 0", tmo_cnt - t0, s_ready, m_valid); end
    finish_block(exp);
    release_out();
`endif
  endtask

  task automatic test_random();
    logic [127:0] pt, got;
    for (int k = 0; k < 3; k++) begin
      new_keys();
      for (int b = 0; b < 2; b++) begin
        pt = rnd128();
        run_full(pt, got);
        total++; if (got !== aes_ref(pt)) begin bad++; $display("FAIL random_block: got %h want %h", got, aes_ref(pt)); end
      end
    end
  endtask

  initial begin
    kill = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_key = 128'h0;
    s_valid = 1'b0; s_data = 128'h0; m_ready = 1'b0;
    core_key_ready = 1'b0; core_out_en = 1'b0; core_out_data = 128'h0;
    core_st = 128'h0;
    build_sbox();
    test_reset();
    test_fips();
    test_mask();
    test_backpressure();
    test_cfg_err();
    test_seq();
    test_kill();
    test_wdog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_128_core_ctrl.md
Name: aes_128_core_ctrl

Overview:
Sequencer wrapped around aes_128_core_full; upstream and downstream see simple valid/ready streams.
- Holds the 11 round keys (whitening key plus rounds 1..10) in a register file loaded over a config port.
- Launches one block at a time into the core and feeds the next round key on every core key_ready.
- Captures the core result and returns it through a 1-deep output buffer.
- Flags protocol, config and timeout errors.

Parameters:
- NR, 10, number of AES rounds; the key file holds NR+1 entries.
- TMO_CYCLES, 64, watchdog limit in clocks from launch to core out_en.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- kill  in  1  reset, synchronous, active-high.
- cfg_we  in  1  round-key write strobe.
- cfg_addr  in  4  key index 0..NR.
- cfg_key  in  128  round-key value.
- s_valid  in  1  input block valid.
- s_data  in  128  plaintext block.
- s_ready  out  1  controller accepts the block.
- core_in_en  out  1  to core in_en.
- core_in_data  out  128  to core in_data.
- core_key_round  out  128  to core key_round.
- core_key_ready  in  1  from core key_ready.
- core_out_en  in  1  from core out_en.
- core_out_data  in  128  from core out_data.
- m_valid  out  1  result valid.
- m_data  out  128  ciphertext.
- m_ready  in  1  downstream accepts.
- cfg_err  out  1  1-cycle pulse: bad config write.
- seq_err  out  1  1-cycle pulse: core protocol violation.
- tmo_err  out  1  1-cycle pulse: watchdog expiry.

Behaviour:
- Reset (kill=1 at a clk edge): state=IDLE, key_idx=0, loaded mask=0, core_in_en=0, core_in_data=0, m_valid=0, m_data=0, all err=0. Key register contents are not cleared, but the mask forces a full reload.
- Reset mid-operation: the block in flight is dropped with no m_valid. The core is reset by the same kill.
- core_key_round = key[key_idx], combinational from the register file.
- FSM states: IDLE, LAUNCH, RUN, HOLD.
- s_ready = (state==IDLE) & (mask all-ones) & !m_valid.
- IDLE: on s_valid&s_ready, register s_data, set key_idx=0, go to LAUNCH.
- LAUNCH: core_in_en=1 and core_in_data=block for exactly 1 cycle, then RUN. core_in_data returns to 0 otherwise.
- RUN, core_key_ready=1: key_idx<=key_idx+1, visible on the next cycle.
- RUN, core_key_ready with key_idx==NR: saturate and pulse seq_err.
- RUN, core_out_en: m_data<=core_out_data, m_valid<=1, go to HOLD.
- RUN, core_out_en seen with key_idx!=NR: still captured, but pulse seq_err.
- core_out_en or core_key_ready outside RUN: ignored, pulse seq_err.
- core_key_ready and core_out_en in the same cycle: out_en wins, key_idx is not incremented.
- HOLD: m_valid held with m_data stable until m_ready; then m_valid<=0, state IDLE, key_idx<=0.
- Latency: input accept to core_in_en is 1 cycle. core_out_en to m_valid is 1 cycle.
- Config writes: accepted only in IDLE with cfg_addr<=NR; write key and set mask bit.
- Config writes while not in IDLE, or with cfg_addr>NR: dropped, pulse cfg_err.
- Config write in the same cycle as a handshake: handshake is taken first, write is dropped with cfg_err.

Optional Feature:
Macro AES_CTRL_WDOG_EN.
- Defined: a counter clears on LAUNCH and increments in RUN. On reaching TMO_CYCLES, pulse tmo_err, drop the block (no m_valid) and return to IDLE with key_idx=0.
- Not defined: RUN waits indefinitely, tmo_err is tied 0, and the counter is absent.

Decomposition:
- Shared package aes_ctrl_pkg:
  - state encoding typedef (IDLE/LAUNCH/RUN/HOLD);
  - AES_NR=10, AES_NKEYS=11, AES_BLK_W=128.
- One sub-module, aes_rkey_mem: 11x128 register file with write port, loaded mask and async read by key_idx.

Test Plan:
1. Load keys 0..10 (key0=0f0e0d0c0b0a09080706050403020100, key10=c5302b4d8ba707f3174a94e37f1d1113), send s_data=ffeeddccbbaa99887766554433221100 into the core model -> m_data=5ac5b47080b7cdd830047b6ad8e0c469, key_idx advances once per key_ready, m_valid 1 cycle after out_en.
2. Load only keys 0..9 -> s_ready stays 0; write key10 -> s_ready=1 the next cycle.
3. Hold m_ready=0 for 5 cycles after result -> m_valid/m_data stable, s_ready=0; m_ready=1 -> next block accepted.
4. cfg_we during RUN, and cfg_addr=12 in IDLE -> cfg_err pulses, key contents unchanged, result still correct.
5. Inject an 11th key_ready, then a stray out_en in IDLE -> seq_err pulses, key_idx stays 10.
6. Assert kill in RUN -> no m_valid, mask=0, s_ready=0. With AES_CTRL_WDOG_EN and a core with out_en suppressed -> tmo_err at TMO_CYCLES=64, state IDLE.
